exe_muldiv_unit: RTL and testbench
==================================

EXE_MULDIV_UNIT -- requirements
Module: exe_muldiv_unit

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock.
REQ-002 SHALL have reset, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have exe_instr_in, input, 32, instruction currently in EXE (from ID/EXE register instr output).
REQ-004 SHALL have exe_opr_a, input, 32, GPR[rs] value in EXE.
REQ-005 SHALL have exe_opr_b, input, 32, GPR[rt] value in EXE.
REQ-006 SHALL have exe_valid, input, 1, EXE holds a real instruction (not a bubble).
REQ-007 SHALL have exe_advance, input, 1, ID/EXE register loads a new instruction at this edge.
REQ-008 SHALL have exe_flush, input, 1, EXE instruction is squashed this cycle.
REQ-009 SHALL have muldiv_stall, output, 1, request to PipelineController to hold IF/ID/EXE.
REQ-010 SHALL have hilo_rdata, output, 32, HI for mfhi, LO for mflo, else 0.
REQ-011 SHALL have div_zero, output, 1, one-cycle pulse on divide-by-zero completion.
REQ-012 SHALL have hi_out and lo_out, output, 32 each, architectural HI/LO registers.

Function
REQ-013 SHALL decode only opcode 000000, funct: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
REQ-014 SHALL implement FSM IDLE, BUSY, DONE; IDLE->BUSY on valid mult/multu/div/divu, exe_flush=0.
REQ-015 SHALL latch operands, op type and signedness at IDLE->BUSY edge; 6-bit iteration counter cleared.
REQ-016 SHALL assert muldiv_stall combinationally in the start cycle and every BUSY cycle.
REQ-017 SHALL run exactly 32 BUSY cycles (one radix-2 step each), then BUSY->DONE, writing HI/LO at that edge.
REQ-018 SHALL hold DONE with muldiv_stall=0 until exe_advance=1, then go to IDLE; no restart from DONE.
REQ-019 Total stall per mul/div SHALL be 33 cycles; the instruction leaves EXE no earlier than cycle 34.
REQ-020 mult/multu SHALL produce the full 64-bit product, HI=[63:32], LO=[31:0]; mult signed two's complement.
REQ-021 div/divu SHALL give LO=quotient, HI=remainder; signed: quotient truncates toward zero, remainder takes dividend sign.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-023 Divide by zero (either signedness) SHALL give HI=exe_opr_a, LO=0xFFFFFFFF, with the same 33-cycle latency and div_zero high for the DONE-entry cycle.
REQ-024 mthi/mtlo SHALL write HI/LO at the end of a valid, unflushed IDLE cycle, with no stall.
REQ-025 hilo_rdata SHALL be combinational from current HI/LO; a mfhi/mflo following mthi/mtlo or mul/div reads the new value.
REQ-026 exe_flush in BUSY SHALL abort to IDLE, HI/LO unchanged, stall drops the same cycle.
REQ-027 exe_flush in DONE SHALL return to IDLE; HI/LO already written are kept.
REQ-028 Invalid/bubble instructions (exe_valid=0) SHALL cause no state change.

Reset
REQ-029 reset low SHALL force IDLE; HI, LO and counter SHALL be 0; muldiv_stall and div_zero SHALL be 0; all outputs SHALL be 0.
REQ-030 reset mid-BUSY SHALL abandon the operation without writing HI/LO.

Structure
REQ-031 Funct codes, FSM state encodings and ITER_COUNT=32 SHALL live in shared package mips_exe_pkg.
REQ-032 The iterative shift-add/restoring-subtract datapath SHALL be sub-module muldiv_core (operand magnitude in, 64-bit raw result out); sign fix-up and the FSM remain in the top.

Verification
REQ-033 multu 0xFFFFFFFF x 0xFFFFFFFF -> stall 33 cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 mult -7 x 3 then mfhi, mflo -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; mfhi returns 0xFFFFFFFF with no extra stall.
REQ-035 div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100 / 0 -> HI=100, LO=0xFFFFFFFF, div_zero one pulse.
REQ-036 mthi 0x1234 then mfhi next cycle -> hilo_rdata=0x1234, muldiv_stall never asserted.
REQ-037 divu 10/3 with exe_flush at BUSY cycle 10 -> IDLE next cycle, HI/LO retain prior values; reset low at BUSY cycle 5 -> HI=LO=0, stall=0.
REQ-038 mult completing with exe_advance held 0 for 3 cycles -> FSM stays DONE, stall=0, no second operation, HI/LO written once.

Source files
------------

// File: rtl/mips_exe_pkg.sv
// Shared EXE-stage constants for the multiply/divide unit.
// Funct codes, FSM encoding, iteration count, magnitude helper.
package mips_exe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  function automatic logic [31:0] mag32(
    input logic [31:0] x,
    input logic        sgn
  );
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 iterative datapath: shift-add multiply, restoring divide.
// Works on magnitudes; raw_o is the value the registers take next edge.
module muldiv_core
  import mips_exe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        is_div_i,
  input  logic [31:0] a_mag_i,
  input  logic [31:0] b_mag_i,
  output logic [63:0] raw_o
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] m_q, m_d;
  logic [32:0] rem;
  logic [32:0] sum;
  logic [64:0] shf;
  logic        ge;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    m_d  = m_q;
    rem  = '0;
    sum  = '0;
    shf  = '0;
    ge   = 1'b0;
    if (load_i) begin
      hi_d = '0;
      lo_d = a_mag_i;
      m_d  = b_mag_i;
    end else if (step_i) begin
      if (is_div_i) begin
        rem = {hi_q, lo_q[31]};
        ge  = (rem >= {1'b0, m_q});
        if (ge) rem = rem - {1'b0, m_q};
        hi_d = rem[31:0];
        lo_d = {lo_q[30:0], ge};
      end else begin
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 33'd0);
        shf = {sum, lo_q} >> 1;
        hi_d = shf[63:32];
        lo_d = shf[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q  <= m_d;
    end
  end

  assign raw_o = {hi_d, lo_d};

endmodule

// File: rtl/exe_muldiv_unit.sv
// EXE-stage HI/LO unit: mult/div FSM, sign fix-up, mfhi/mflo/mthi/mtlo.
// Holds the pipeline for 33 cycles per multiply or divide.
module exe_muldiv_unit
  import mips_exe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] exe_instr_in,
  input  logic [31:0] exe_opr_a,
  input  logic [31:0] exe_opr_b,
  input  logic        exe_valid,
  input  logic        exe_advance,
  input  logic        exe_flush,
  output logic        muldiv_stall,
  output logic [31:0] hilo_rdata,
  output logic        div_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_div_q, op_div_d;
  logic        op_sgn_q, op_sgn_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dz_q, dz_d;

  logic        is_r;
  logic        d_mult, d_multu, d_div, d_divu;
  logic        d_mfhi, d_mthi, d_mflo, d_mtlo;
  logic        is_md, live;
  logic        start, step, finish, stall_c;
  logic [63:0] raw;
  logic [63:0] prod;
  logic [31:0] quo, rmd;
  logic        unused_instr;

  assign unused_instr = ^exe_instr_in[25:6];
  assign is_r = (exe_instr_in[31:26] == OP_SPECIAL);

  always_comb begin
    d_mult  = 1'b0;
    d_multu = 1'b0;
    d_div   = 1'b0;
    d_divu  = 1'b0;
    d_mfhi  = 1'b0;
    d_mthi  = 1'b0;
    d_mflo  = 1'b0;
    d_mtlo  = 1'b0;
    if (is_r) begin
      unique case (1'b1)
        (exe_instr_in[5:0] == F_MULT):  d_mult  = 1'b1;
        (exe_instr_in[5:0] == F_MULTU): d_multu = 1'b1;
        (exe_instr_in[5:0] == F_DIV):   d_div   = 1'b1;
        (exe_instr_in[5:0] == F_DIVU):  d_divu  = 1'b1;
        (exe_instr_in[5:0] == F_MFHI):  d_mfhi  = 1'b1;
        (exe_instr_in[5:0] == F_MTHI):  d_mthi  = 1'b1;
        (exe_instr_in[5:0] == F_MFLO):  d_mflo  = 1'b1;
        (exe_instr_in[5:0] == F_MTLO):  d_mtlo  = 1'b1;
        default: ;
      endcase
    end
  end

  assign is_md = d_mult | d_multu | d_div | d_divu;
  assign live  = exe_valid & ~exe_flush;

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    start   = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (live && is_md) begin
          start   = 1'b1;
          stall_c = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (exe_flush) begin
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          step    = 1'b1;
          if (cnt_q == 6'(ITER_COUNT - 1)) begin
            finish  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (exe_flush || exe_advance) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  muldiv_core u_core (
    .clk      (clk),
    .reset    (reset),
    .load_i   (start),
    .step_i   (step),
    .is_div_i (op_div_q),
    .a_mag_i  (mag32(exe_opr_a, d_mult | d_div)),
    .b_mag_i  (mag32(exe_opr_b, d_mult | d_div)),
    .raw_o    (raw)
  );

  // Core works on magnitudes; restore signs from the latched operands.
  assign prod = (op_sgn_q && (a_q[31] ^ b_q[31])) ? (~raw + 64'd1) : raw;
  assign quo  = (op_sgn_q && (a_q[31] ^ b_q[31])) ? (~raw[31:0] + 32'd1)
                                                  : raw[31:0];
  assign rmd  = (op_sgn_q && a_q[31]) ? (~raw[63:32] + 32'd1) : raw[63:32];

  always_comb begin
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    op_sgn_d = op_sgn_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = 1'b0;
    if (start) begin
      cnt_d    = '0;
      op_div_d = d_div | d_divu;
      op_sgn_d = d_mult | d_div;
      a_d      = exe_opr_a;
      b_d      = exe_opr_b;
    end else if (step) begin
      cnt_d = cnt_q + 6'd1;
    end
    if (finish) begin
      if (!op_div_q) begin
        hi_d = prod[63:32];
        lo_d = prod[31:0];
      end else if (b_q == '0) begin
        hi_d = a_q;
        lo_d = 32'hFFFF_FFFF;
        dz_d = 1'b1;
      end else begin
        hi_d = rmd;
        lo_d = quo;
      end
    end else if (state_q == S_IDLE && live) begin
      if (d_mthi) hi_d = exe_opr_a;
      if (d_mtlo) lo_d = exe_opr_a;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      op_sgn_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      op_sgn_q <= op_sgn_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  assign muldiv_stall = stall_c & reset;
  assign div_zero     = dz_q;
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;
  assign hilo_rdata   = d_mfhi ? hi_q : (d_mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Self-checking bench for exe_muldiv_unit: vector table of mul/div ops
// plus directed sequences for flush, reset, DONE hold and mthi/mtlo.
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        valid = 1'b0;
  logic        adv = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] rdata;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vt[10];

  exe_muldiv_unit dut (
    .clk          (clk),
    .reset        (reset),
    .exe_instr_in (instr),
    .exe_opr_a    (opa),
    .exe_opr_b    (opb),
    .exe_valid    (valid),
    .exe_advance  (adv),
    .exe_flush    (flush),
    .muldiv_stall (stall),
    .hilo_rdata   (rdata),
    .div_zero     (dz),
    .hi_out       (hi),
    .lo_out       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    instr = {26'd0, f};
    opa   = a;
    opb   = b;
    valid = 1'b1;
    #1;
  endtask

  // Runs until stall drops (DONE entry); returns stalled cycle count.
  task automatic wait_done(output int n);
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick();
    end
    if (n >= 100) check("stall_timeout", 64'(n), 64'd33);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    issue(v.funct, v.a, v.b);
    wait_done(n);
    check("stall_cycles", 64'(n), 64'd33);
    check("hi", 64'(hi), 64'(v.hi));
    check("lo", 64'(lo), 64'(v.lo));
    check("div_zero", 64'(dz), 64'(v.dz));
    adv = 1'b1;
    tick();
    adv = 1'b0;
    check("div_zero_clear", 64'(dz), 64'd0);
    issue(MFHI, 32'd0, 32'd0);
    check("mfhi", 64'(rdata), 64'(v.hi));
    check("mfhi_nostall", 64'(stall), 64'd0);
    tick();
    issue(MFLO, 32'd0, 32'd0);
    check("mflo", 64'(rdata), 64'(v.lo));
    tick();
    valid = 1'b0;
    instr = '0;
    #1;
  endtask

  initial begin
    int n;
    vt[0] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vt[1] = '{MULT, 32'hFFFF_FFF9, 32'd3,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vt[2] = '{DIV, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vt[3] = '{DIVU, 32'd100, 32'd0,
              32'd100, 32'hFFFF_FFFF, 1'b1};
    vt[4] = '{DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000, 1'b0};
    vt[5] = '{MULT, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'd0, 1'b0};
    vt[6] = '{DIVU, 32'd10, 32'd3,
              32'd1, 32'd3, 1'b0};
    vt[7] = '{DIV, 32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD, 1'b0};
    vt[8] = '{DIV, 32'hFFFF_FFFB, 32'd0,
              32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vt[9] = '{MULTU, 32'h1234_5678, 32'h10,
              32'd1, 32'h2345_6780, 1'b0};

    // Reset state, with a mult sitting in EXE
    instr = {26'd0, MULT};
    opa = 32'd5;
    opb = 32'd6;
    valid = 1'b1;
    #12;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    valid = 1'b0;
    instr = '0;
    reset = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // mthi then mfhi, no stall anywhere
    issue(MTHI, 32'h1234, 32'd0);
    check("mthi_nostall", 64'(stall), 64'd0);
    tick();
    issue(MFHI, 32'd0, 32'd0);
    check("mthi_mfhi", 64'(rdata), 64'h1234);
    check("mfhi_nostall2", 64'(stall), 64'd0);
    tick();
    issue(MTLO, 32'hBBBB, 32'd0);
    tick();
    issue(MTHI, 32'hAAAA, 32'd0);
    tick();
    issue(MFLO, 32'd0, 32'd0);
    check("mtlo_mflo", 64'(rdata), 64'hBBBB);
    tick();

    // Flush at BUSY cycle 10
    issue(DIVU, 32'd10, 32'd3);
    check("start_stall", 64'(stall), 64'd1);
    tick();
    for (int i = 2; i <= 10; i++) tick();
    check("busy10_stall", 64'(stall), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_stall_drop", 64'(stall), 64'd0);
    tick();
    flush = 1'b0;
    valid = 1'b0;
    #1;
    check("flush_idle_stall", 64'(stall), 64'd0);
    repeat (40) tick();
    check("flush_hi_kept", 64'(hi), 64'hAAAA);
    check("flush_lo_kept", 64'(lo), 64'hBBBB);

    // Reset at BUSY cycle 5
    issue(MULT, 32'd7, 32'd9);
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("rstbusy_hi", 64'(hi), 64'd0);
    check("rstbusy_lo", 64'(lo), 64'd0);
    check("rstbusy_stall", 64'(stall), 64'd0);
    valid = 1'b0;
    #2;
    reset = 1'b1;
    repeat (40) tick();
    check("rstbusy_hi_after", 64'(hi), 64'd0);
    check("rstbusy_lo_after", 64'(lo), 64'd0);

    // DONE held with advance low, operands changing
    issue(MULT, 32'd3, 32'd4);
    wait_done(n);
    check("hold_cycles", 64'(n), 64'd33);
    opa = 32'd5;
    opb = 32'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_stall", 64'(stall), 64'd0);
      check("hold_lo", 64'(lo), 64'd12);
    end
    repeat (40) tick();
    check("hold_no_restart_lo", 64'(lo), 64'd12);
    check("hold_no_restart_hi", 64'(hi), 64'd0);
    adv = 1'b1;
    tick();
    adv = 1'b0;
    valid = 1'b0;
    #1;

    // Flush in DONE keeps written result
    issue(MULT, 32'd2, 32'hFFFF_FFFD);
    wait_done(n);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    #1;
    check("dflush_hi", 64'(hi), 64'hFFFF_FFFF);
    check("dflush_lo", 64'(lo), 64'hFFFF_FFFA);
    check("dflush_stall", 64'(stall), 64'd0);
    issue(MFLO, 32'd0, 32'd0);
    check("dflush_mflo", 64'(rdata), 64'hFFFF_FFFA);
    tick();

    // Bubble carrying a mult encoding does nothing
    valid = 1'b0;
    instr = {26'd0, MULT};
    opa = 32'd1;
    opb = 32'd1;
    #1;
    check("bubble_stall", 64'(stall), 64'd0);
    repeat (35) tick();
    check("bubble_lo", 64'(lo), 64'hFFFF_FFFA);
    check("bubble_stall_after", 64'(stall), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
